// File: rtl/reg_file_mp.sv
// reg_file_mp: register file with two read ports, two write ports and a pending (busy) bit per register.
// Register 0 always reads as zero. Port 1 wins when both write ports target the same register.
// A same-cycle dual write raises writeCollision for one cycle.
// Optional macro REG_FILE_MP_BYPASS_EN forwards same-cycle write data and busy state to matching reads.
module reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] registerAddressA,
  input  logic [ADDR_WIDTH-1:0] registerAddressB,
  output logic [DATA_WIDTH-1:0] registerDataA,
  output logic [DATA_WIDTH-1:0] registerDataB,
  input  logic [ADDR_WIDTH-1:0] writeAddress0,
  input  logic [ADDR_WIDTH-1:0] writeAddress1,
  input  logic [DATA_WIDTH-1:0] writeData0,
  input  logic [DATA_WIDTH-1:0] writeData1,
  input  logic                  writeEnable0,
  input  logic                  writeEnable1,
  input  logic                  busySetEnable,
  input  logic [ADDR_WIDTH-1:0] busySetAddress,
  output logic                  busyA,
  output logic                  busyB,
  output logic                  writeCollision
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy, busyNext;
  logic write0Hit, write1Hit, setHit, collision;
  // Effective write strobes: register 0 is never written, and port 0 yields to port 1 on a shared target.
  always_comb begin
    write1Hit = writeEnable1 && (writeAddress1 != '0);
    write0Hit = writeEnable0 && (writeAddress0 != '0) && !(write1Hit && (writeAddress1 == writeAddress0));
    setHit = busySetEnable && (busySetAddress != '0);
    collision = writeEnable0 && write1Hit && (writeAddress0 == writeAddress1);
  end
  // Register array; cleared asynchronously, register 0 stays zero forever.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (write0Hit) regs[writeAddress0] <= writeData0;
      if (write1Hit) regs[writeAddress1] <= writeData1;
    end
  end
  // Busy update: a write clears its target, a set (applied last) marks a new producer.
  always_comb begin
    busyNext = busy;
    if (write0Hit) busyNext[writeAddress0] = 1'b0;
    if (write1Hit) busyNext[writeAddress1] = 1'b0;
    if (setHit) busyNext[busySetAddress] = 1'b1;
  end
  // Busy bits and the one-cycle collision flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy <= '0;
      writeCollision <= 1'b0;
    end else begin
      busy <= busyNext;
      writeCollision <= collision;
    end
  end
  // Read port A: stored value, optionally overridden by a same-cycle write, forced to zero in reset.
  always_comb begin
    registerDataA = regs[registerAddressA];
    busyA = busy[registerAddressA];
`ifdef REG_FILE_MP_BYPASS_EN
    if (write0Hit && (writeAddress0 == registerAddressA)) begin
      registerDataA = writeData0;
      busyA = setHit && (busySetAddress == registerAddressA);
    end
    if (write1Hit && (writeAddress1 == registerAddressA)) begin
      registerDataA = writeData1;
      busyA = setHit && (busySetAddress == registerAddressA);
    end
`endif
    if (!reset) begin
      registerDataA = '0;
      busyA = 1'b0;
    end
  end
  // Read port B: identical lookup for the second read address.
  always_comb begin
    registerDataB = regs[registerAddressB];
    busyB = busy[registerAddressB];
`ifdef REG_FILE_MP_BYPASS_EN
    if (write0Hit && (writeAddress0 == registerAddressB)) begin
      registerDataB = writeData0;
      busyB = setHit && (busySetAddress == registerAddressB);
    end
    if (write1Hit && (writeAddress1 == registerAddressB)) begin
      registerDataB = writeData1;
      busyB = setHit && (busySetAddress == registerAddressB);
    end
`endif
    if (!reset) begin
      registerDataB = '0;
      busyB = 1'b0;
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed and randomized checks of reg_file_mp against an array-based reference model.
module tb_reg_file_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int N = 2 ** AW;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [AW-1:0] registerAddressA, registerAddressB, writeAddress0, writeAddress1, busySetAddress;
  logic [DW-1:0] registerDataA, registerDataB, writeData0, writeData1;
  logic writeEnable0, writeEnable1, busySetEnable, busyA, busyB, writeCollision;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mMem [N];
  logic mBusy [N];
  logic mCol;

  reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .registerAddressA(registerAddressA), .registerAddressB(registerAddressB),
    .registerDataA(registerDataA), .registerDataB(registerDataB),
    .writeAddress0(writeAddress0), .writeAddress1(writeAddress1),
    .writeData0(writeData0), .writeData1(writeData1),
    .writeEnable0(writeEnable0), .writeEnable1(writeEnable1),
    .busySetEnable(busySetEnable), .busySetAddress(busySetAddress),
    .busyA(busyA), .busyB(busyB), .writeCollision(writeCollision)
  );

  always #5 clock = ~clock;

  // Reference model: sequential application of port 0 then port 1 then busy set gives the priority rules.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        mMem[i] = '0;
        mBusy[i] = 1'b0;
      end
      mCol = 1'b0;
    end else begin
      mCol = writeEnable0 && writeEnable1 && (writeAddress0 == writeAddress1) && (writeAddress0 != 0);
      if (writeEnable0 && writeAddress0 != 0) begin
        mMem[writeAddress0] = writeData0;
        mBusy[writeAddress0] = 1'b0;
      end
      if (writeEnable1 && writeAddress1 != 0) begin
        mMem[writeAddress1] = writeData1;
        mBusy[writeAddress1] = 1'b0;
      end
      if (busySetEnable && busySetAddress != 0) mBusy[busySetAddress] = 1'b1;
    end
  end

  function automatic logic [DW-1:0] expData(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    if (!reset || a == 0) return '0;
    d = mMem[a];
`ifdef REG_FILE_MP_BYPASS_EN
    if (writeEnable0 && writeAddress0 == a) d = writeData0;
    if (writeEnable1 && writeAddress1 == a) d = writeData1;
`endif
    return d;
  endfunction

  function automatic logic expBusy(input logic [AW-1:0] a);
    logic b;
    if (!reset || a == 0) return 1'b0;
    b = mBusy[a];
`ifdef REG_FILE_MP_BYPASS_EN
    if ((writeEnable0 && writeAddress0 == a) || (writeEnable1 && writeAddress1 == a))
      b = busySetEnable && busySetAddress == a;
`endif
    return b;
  endfunction

  task automatic setIdle();
    writeEnable0 = 0; writeEnable1 = 0; busySetEnable = 0;
    writeAddress0 = 0; writeAddress1 = 0; busySetAddress = 0;
    writeData0 = 0; writeData1 = 0;
  endtask

  task automatic test_reset();
    setIdle();
    registerAddressA = 5'd3; registerAddressB = 5'd9;
    writeEnable0 = 1; writeAddress0 = 5'd3; writeData0 = 32'hCAFE0001;
    busySetEnable = 1; busySetAddress = 5'd9;
    @(negedge clock);
    checks++; if (registerDataA !== 32'h0) begin errors++; $display("FAIL reset_dataA got %h want 0", registerDataA); end
    checks++; if (registerDataB !== 32'h0) begin errors++; $display("FAIL reset_dataB got %h want 0", registerDataB); end
    checks++; if ({busyA, busyB, writeCollision} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busyA, busyB, writeCollision}); end
    @(posedge clock); #1;
    setIdle();
    reset = 1;
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (registerDataA !== 32'h0 || busyB !== 1'b0) begin errors++; $display("FAIL reset_no_write got %h/%b want 0/0", registerDataA, busyB); end
    @(posedge clock); #1;
  endtask

  task automatic test_basic_write();
    writeEnable0 = 1; writeAddress0 = 5'd2; writeData0 = 32'h12345678;
    @(posedge clock); #1;
    setIdle();
    registerAddressA = 5'd2; registerAddressB = 5'd0;
    @(negedge clock);
    checks++; if (registerDataA !== 32'h12345678) begin errors++; $display("FAIL basic_readA got %h want 12345678", registerDataA); end
    checks++; if (registerDataB !== 32'h0) begin errors++; $display("FAIL basic_readB_r0 got %h want 0", registerDataB); end
    @(posedge clock); #1;
  endtask

  task automatic test_reg0();
    writeEnable0 = 1; writeAddress0 = 5'd0; writeData0 = 32'hFFFFFFFF;
    busySetEnable = 1; busySetAddress = 5'd0;
    registerAddressA = 5'd0;
    @(posedge clock); #1;
    setIdle();
    @(negedge clock);
    checks++; if (registerDataA !== 32'h0) begin errors++; $display("FAIL reg0_data got %h want 0", registerDataA); end
    checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL reg0_busy got %b want 0", busyA); end
    @(posedge clock); #1;
  endtask

  task automatic test_collision();
    writeEnable0 = 1; writeAddress0 = 5'd5; writeData0 = 32'hAAAA0000;
    writeEnable1 = 1; writeAddress1 = 5'd5; writeData1 = 32'h0000BBBB;
    @(negedge clock);
    checks++; if (writeCollision !== 1'b0) begin errors++; $display("FAIL collision_early got %b want 0", writeCollision); end
    @(posedge clock); #1;
    setIdle();
    registerAddressA = 5'd5;
    @(negedge clock);
    checks++; if (registerDataA !== 32'h0000BBBB) begin errors++; $display("FAIL collision_data got %h want 0000bbbb", registerDataA); end
    checks++; if (writeCollision !== 1'b1) begin errors++; $display("FAIL collision_flag got %b want 1", writeCollision); end
    @(posedge clock); #1;
    @(negedge clock);
    checks++; if (writeCollision !== 1'b0) begin errors++; $display("FAIL collision_oneshot got %b want 0", writeCollision); end
    @(posedge clock); #1;
  endtask

  task automatic test_busy();
    busySetEnable = 1; busySetAddress = 5'd7;
    @(posedge clock); #1;
    setIdle();
    registerAddressA = 5'd7;
    @(negedge clock);
    checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL busy_set got %b want 1", busyA); end
    writeEnable0 = 1; writeAddress0 = 5'd7; writeData0 = 32'h00000777;
    @(posedge clock); #1;
    setIdle();
    @(negedge clock);
    checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL busy_clear got %b want 0", busyA); end
    writeEnable1 = 1; writeAddress1 = 5'd7; writeData1 = 32'h00000778;
    busySetEnable = 1; busySetAddress = 5'd7;
    @(posedge clock); #1;
    setIdle();
    @(negedge clock);
    checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL busy_set_wins got %b want 1", busyA); end
    checks++; if (registerDataA !== 32'h00000778) begin errors++; $display("FAIL busy_set_data got %h want 00000778", registerDataA); end
    @(posedge clock); #1;
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    writeEnable0 = 1; writeAddress0 = 5'd3; writeData0 = 32'h11111111;
    @(posedge clock); #1;
    writeData0 = 32'hDEADBEEF;
    registerAddressA = 5'd3;
`ifdef REG_FILE_MP_BYPASS_EN
    want = 32'hDEADBEEF;
`else
    want = 32'h11111111;
`endif
    @(negedge clock);
    checks++; if (registerDataA !== want) begin errors++; $display("FAIL bypass_same_cycle got %h want %h", registerDataA, want); end
    @(posedge clock); #1;
    setIdle();
    @(negedge clock);
    checks++; if (registerDataA !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_after_edge got %h want deadbeef", registerDataA); end
    @(posedge clock); #1;
  endtask

  task automatic test_async_reset();
    for (int r = 1; r <= 4; r += 2) begin
      writeEnable0 = 1; writeAddress0 = AW'(r); writeData0 = 32'h100 + r;
      writeEnable1 = 1; writeAddress1 = AW'(r + 1); writeData1 = 32'h100 + r + 1;
      busySetEnable = 1; busySetAddress = 5'd9;
      @(posedge clock); #1;
    end
    writeEnable0 = 1; writeAddress0 = 5'd4; writeData0 = 32'h44;
    writeEnable1 = 1; writeAddress1 = 5'd4; writeData1 = 32'h444;
    busySetEnable = 0;
    @(posedge clock); #1;
    setIdle();
    registerAddressA = 5'd4; registerAddressB = 5'd9;
    #1;
    checks++; if (writeCollision !== 1'b1 || registerDataA !== 32'h444 || busyB !== 1'b1) begin errors++; $display("FAIL preload got col=%b a=%h bb=%b want 1/444/1", writeCollision, registerDataA, busyB); end
    writeEnable0 = 1; writeAddress0 = 5'd1; writeData0 = 32'h55;
    busySetEnable = 1; busySetAddress = 5'd2;
    reset = 0;
    #1;
    checks++; if (registerDataA !== 32'h0 || busyB !== 1'b0 || writeCollision !== 1'b0) begin errors++; $display("FAIL async_reset got a=%h bb=%b col=%b want 0/0/0", registerDataA, busyB, writeCollision); end
    for (int r = 1; r <= 4; r++) begin
      registerAddressA = AW'(r); registerAddressB = AW'(5 - r);
      #1;
      checks++; if (registerDataA !== 32'h0 || registerDataB !== 32'h0 || busyA !== 1'b0) begin errors++; $display("FAIL async_reset_r%0d got %h/%h/%b want 0", r, registerDataA, registerDataB, busyA); end
    end
    @(posedge clock); #2;
    reset = 1;
    setIdle();
    registerAddressA = 5'd1; registerAddressB = 5'd2;
    #1;
    checks++; if (registerDataA !== 32'h0 || busyB !== 1'b0) begin errors++; $display("FAIL reset_discard got %h/%b want 0/0", registerDataA, busyB); end
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      writeEnable0 = 1'($urandom_range(0, 1)); writeAddress0 = AW'($urandom_range(0, 7)); writeData0 = $urandom();
      writeEnable1 = 1'($urandom_range(0, 1)); writeAddress1 = AW'($urandom_range(0, 7)); writeData1 = $urandom();
      busySetEnable = ($urandom_range(0, 3) == 0); busySetAddress = AW'($urandom_range(0, 7));
      registerAddressA = AW'($urandom_range(0, 7)); registerAddressB = AW'($urandom_range(0, 7));
      @(negedge clock);
      checks++; if (registerDataA !== expData(registerAddressA)) begin errors++; $display("FAIL rand_dataA it%0d got %h want %h", i, registerDataA, expData(registerAddressA)); end
      checks++; if (registerDataB !== expData(registerAddressB)) begin errors++; $display("FAIL rand_dataB it%0d got %h want %h", i, registerDataB, expData(registerAddressB)); end
      checks++; if (busyA !== expBusy(registerAddressA)) begin errors++; $display("FAIL rand_busyA it%0d got %b want %b", i, busyA, expBusy(registerAddressA)); end
      checks++; if (busyB !== expBusy(registerAddressB)) begin errors++; $display("FAIL rand_busyB it%0d got %b want %b", i, busyB, expBusy(registerAddressB)); end
      checks++; if (writeCollision !== mCol) begin errors++; $display("FAIL rand_collision it%0d got %b want %b", i, writeCollision, mCol); end
      @(posedge clock); #1;
    end
    setIdle();
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_reg0();
    test_collision();
    test_busy();
    test_bypass();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each register and data port.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: address width; depth = 2**ADDR_WIDTH registers.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports registerAddressA and registerAddressB, input, ADDR_WIDTH: read addresses for ports A and B.
REQ-006 SHALL have ports registerDataA and registerDataB, output, DATA_WIDTH: read data for ports A and B.
REQ-007 SHALL have ports writeAddress0 and writeAddress1, input, ADDR_WIDTH: write addresses for write ports 0 and 1.
REQ-008 SHALL have ports writeData0 and writeData1, input, DATA_WIDTH: write data for write ports 0 and 1.
REQ-009 SHALL have ports writeEnable0 and writeEnable1, input, 1: write strobes for write ports 0 and 1.
REQ-010 SHALL have port busySetEnable, input, 1: marks the register at busySetAddress as pending.
REQ-011 SHALL have port busySetAddress, input, ADDR_WIDTH: register to mark pending.
REQ-012 SHALL have ports busyA and busyB, output, 1: pending flag of the register addressed by the matching read port.
REQ-013 SHALL have port writeCollision, output, 1: registered flag for a same-cycle dual write to one register.

Function
REQ-014 SHALL read both ports combinationally from the register array, with no clock latency.
REQ-015 SHALL return 0 on any read of register 0 and ignore all writes to it.
REQ-016 SHALL never report register 0 as busy.
REQ-017 SHALL perform each enabled write on the rising clock edge, where address is nonzero.
REQ-018 SHALL write writeData1 only when both write ports target the same nonzero address in one cycle; port 1 has priority.
REQ-019 SHALL set writeCollision to 1 for exactly one cycle after such a dual write, and hold it at 0 otherwise.
REQ-020 SHALL clear a register's busy bit on the edge that writes it.
REQ-021 SHALL set a register's busy bit on the edge where busySetEnable=1 for its address.
REQ-022 SHALL let the set win when a set and a write hit the same register on the same edge, leaving the bit at 1 (new producer).
REQ-023 SHALL leave the busy bit unchanged when a write hits a register whose busy bit is already 0.
REQ-024 SHALL drive busyA/busyB as combinational lookups of the current busy bits, after any bypass adjustment (REQ-028).

Reset
REQ-025 SHALL, on reset low, immediately and asynchronously clear all registers to 0, clear all busy bits, and clear writeCollision.
REQ-026 SHALL, during reset, drive registerDataA/B=0, busyA/B=0 and writeCollision=0 regardless of other inputs.
REQ-027 SHALL ignore writes and busy sets while reset is low; a reset asserted mid-cycle discards the pending write.

Configuration
REQ-028 SHALL, when macro REG_FILE_MP_BYPASS_EN is defined, forward a same-cycle enabled write to a matching nonzero read address: read data = incoming write data (port 1 over port 0), and busy = 0 unless busySetEnable also targets that address.
REQ-029 SHALL, when REG_FILE_MP_BYPASS_EN is undefined, have reads return only the stored value and stored busy bit; a write becomes visible the cycle after its edge.

Verification
REQ-030 SHALL cover: after reset, write reg 2 = 0x12345678 via port 0, then read A=2 -> registerDataA=0x12345678 on the next cycle; B=0 -> 0.
REQ-031 SHALL cover: write reg 0 = 0xFFFFFFFF -> reading address 0 returns 0x00000000 and busyA=0.
REQ-032 SHALL cover: both ports write reg 5 (0xAAAA0000 on port 0, 0x0000BBBB on port 1) -> reg 5 = 0x0000BBBB and writeCollision=1 for exactly one cycle.
REQ-033 SHALL cover: busySet reg 7, read A=7 -> busyA=1; next write of reg 7 -> busyA=0; a set and write to reg 7 on the same edge -> busyA=1.
REQ-034 SHALL cover: with REG_FILE_MP_BYPASS_EN defined, write reg 3 = 0xDEADBEEF while A=3 -> registerDataA=0xDEADBEEF in the same cycle; with it undefined, the old value is returned until after the edge.
REQ-035 SHALL cover: reset asserted asynchronously between edges after loading regs 1-4 -> all reads 0, busy and writeCollision 0, immediately without waiting for an edge.
